// File: rtl/conv_seq_pkg.sv
// Shared definitions for the conv tile sequencer: tile geometry, core inst
// word bit positions, FSM state encoding and the registered output bundle.
package conv_seq_pkg;

  // Tile geometry for the 8x8 weight-stationary core and a 6x6 / 3x3 conv.
  localparam int unsigned COL         = 8;
  localparam int unsigned ROW         = 8;
  localparam int unsigned LEN_NIJ     = 36;
  localparam int unsigned IW          = 6;
  localparam int unsigned K           = 3;
  localparam int unsigned LEN_KIJ     = 9;
  localparam int unsigned LEN_ONIJ    = 16;
  localparam int unsigned OW          = 4;
  localparam int unsigned PSUM_STRIDE = 37;
  localparam int unsigned RST_CYC     = 11;
  localparam int unsigned GAP_CYC     = 11;
  localparam logic [10:0] WBASE       = 11'd1024;

  // Core inst word layout, MSB first.
  localparam int ACC_B  = 33;
  localparam int CENP_B = 32;
  localparam int WENP_B = 31;
  localparam int AP_LSB = 20;  // A_p occupies [30:20]
  localparam int CENX_B = 19;
  localparam int WENX_B = 18;
  localparam int AX_LSB = 7;   // A_x occupies [17:7]
  localparam int OFRD_B = 6;
  localparam int IFWR_B = 5;
  localparam int IFRD_B = 4;
  localparam int L0RD_B = 3;
  localparam int L0WR_B = 2;
  localparam int EXEC_B = 1;
  localparam int LOAD_B = 0;

  // Both memories disabled and in read mode, all strobes low.
  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    IDLE, KRST, WL0, LOAD, GAP, AL0, EXEC, DRAIN, OWAIT, OFIFO, ACC, DONE
  } state_e;

  // Everything that leaves the block through a register, except kij_idx.
  typedef struct packed {
    logic [33:0] inst;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic [3:0]  out_idx;
  } out_t;

  localparam out_t OUT_IDLE = '{
    inst:      INST_IDLE,
    core_rst:  1'b0,
    busy:      1'b0,
    done:      1'b0,
    out_valid: 1'b0,
    out_idx:   4'd0
  };

endpackage

// File: rtl/psum_addr_gen.sv
// pmem address of the psum that kernel tap j contributes to output pixel o:
// the kij block base plus the input-grid position under that tap.
module psum_addr_gen
  import conv_seq_pkg::*;
(
  input  logic [3:0]  o_i,
  input  logic [3:0]  j_i,
  output logic [10:0] a_p_o
);

  logic [10:0] o_w;
  logic [10:0] j_w;
  logic [10:0] row_w;
  logic [10:0] col_w;

  assign o_w   = {7'd0, o_i};
  assign j_w   = {7'd0, j_i};
  assign row_w = o_w / 11'(OW) + j_w / 11'(K);
  assign col_w = o_w % 11'(OW) + j_w % 11'(K);

  // All terms stay well inside 11 bits for the supported geometry.
  assign a_p_o = j_w * 11'(PSUM_STRIDE) + row_w * 11'(IW) + col_w;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Autonomous sequencer for one 3x3 conv tile on the 8x8 core. Per kernel tap
// it clears the core, loads weights, streams activations, drains the OFIFO
// into pmem; after the last tap it accumulates psums per output pixel.
// Outputs are decoded from next-state values and registered, so every output
// lines up with the state the FSM is in during that cycle.
module conv_seq_ctrl
  import conv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,        // asynchronous, active low
  input  logic        start,
  input  logic        abort,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  output logic [3:0]  out_idx,
  output logic [3:0]  kij_idx
);

  state_e      state_q, state_d;
  logic [5:0]  t_q, t_d;        // phase counter shared by the per-kij phases
  logic [3:0]  kij_q, kij_d;    // kernel tap
  logic [3:0]  o_q, o_d;        // output pixel during ACC
  logic [3:0]  c_q, c_d;        // cycle within an ACC slot
  out_t        out_q, out_d;
  logic [3:0]  acc_j;
  logic [10:0] acc_ap;

  // Slot cycle c reads tap c-1; only meaningful for c = 1..LEN_KIJ.
  assign acc_j = c_d - 4'd1;

  psum_addr_gen u_psum_addr_gen (
    .o_i   (o_d),
    .j_i   (acc_j),
    .a_p_o (acc_ap)
  );

  // Next-state logic: phase lengths, kij/pixel stepping, abort override.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    t_d     = t_q + 6'd1;
    kij_d   = kij_q;
    o_d     = o_q;
    c_d     = c_q;
    unique case (state_q)
      IDLE: begin
        t_d = '0;
        if (start) begin
          state_d = KRST;
          kij_d   = '0;
        end
      end
      KRST:  if (t_q == 6'(RST_CYC - 1))      begin state_d = WL0;   t_d = '0; end
      WL0:   if (t_q == 6'(COL))              begin state_d = LOAD;  t_d = '0; end
      LOAD:  if (t_q == 6'(COL - 1))          begin state_d = GAP;   t_d = '0; end
      GAP:   if (t_q == 6'(GAP_CYC - 1))      begin state_d = AL0;   t_d = '0; end
      AL0:   if (t_q == 6'(LEN_NIJ))          begin state_d = EXEC;  t_d = '0; end
      EXEC:  if (t_q == 6'(LEN_NIJ - 1))      begin state_d = DRAIN; t_d = '0; end
      DRAIN: if (t_q == 6'(ROW + COL - 1))    begin state_d = OWAIT; t_d = '0; end
      OWAIT: begin
        // Unbounded wait: the core must eventually present its outputs.
        t_d = '0;
        if (ofifo_valid) state_d = OFIFO;
      end
      OFIFO: begin
        if (t_q == 6'(PSUM_STRIDE - 1)) begin
          t_d = '0;
          if (kij_q == 4'(LEN_KIJ - 1)) begin
            state_d = ACC;
            o_d     = '0;
            c_d     = '0;
          end else begin
            state_d = KRST;
            kij_d   = kij_q + 4'd1;
          end
        end
      end
      ACC: begin
        t_d = '0;
        if (c_q == 4'(LEN_KIJ + 2)) begin
          c_d = '0;
          if (o_q == 4'(LEN_ONIJ - 1)) state_d = DONE;
          else                         o_d = o_q + 4'd1;
        end else begin
          c_d = c_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition, including a start in IDLE.
    if (abort) state_d = IDLE;
    if (state_d == IDLE) begin
      t_d   = '0;
      kij_d = '0;
      o_d   = '0;
      c_d   = '0;
    end
  end

  // Output decode from the upcoming state and counters.
  always_comb begin
    out_d      = OUT_IDLE;
    out_d.busy = (state_d != IDLE);
    case (state_d)
      KRST: out_d.core_rst = 1'b1;
      WL0: begin
        out_d.inst[CENX_B]          = 1'b0;
        out_d.inst[AX_LSB +: 11]    = WBASE + 11'(kij_d) * 11'(COL) + 11'(t_d);
        out_d.inst[L0WR_B]          = (t_d != '0);
      end
      LOAD: begin
        out_d.inst[L0RD_B] = 1'b1;
        out_d.inst[LOAD_B] = 1'b1;
      end
      AL0: begin
        out_d.inst[CENX_B]       = 1'b0;
        out_d.inst[AX_LSB +: 11] = 11'(t_d);
        out_d.inst[L0WR_B]       = (t_d != '0);
      end
      EXEC: begin
        out_d.inst[EXEC_B] = 1'b1;
        out_d.inst[L0RD_B] = 1'b1;
      end
      OFIFO: begin
        out_d.inst[OFRD_B]       = 1'b1;
        out_d.inst[CENP_B]       = 1'b0;
        out_d.inst[WENP_B]       = 1'b0;
        out_d.inst[AP_LSB +: 11] = 11'(kij_d) * 11'(PSUM_STRIDE) + 11'(t_d);
      end
      ACC: begin
        if (c_d == 4'd0) out_d.core_rst = 1'b1;
        if (c_d >= 4'd1 && c_d <= 4'(LEN_KIJ)) begin
          out_d.inst[CENP_B]       = 1'b0;
          out_d.inst[AP_LSB +: 11] = acc_ap;
        end
        // pmem read data arrives one cycle after the address.
        out_d.inst[ACC_B] = (c_d >= 4'd2 && c_d <= 4'(LEN_KIJ + 1));
        if (c_d == 4'(LEN_KIJ + 2)) begin
          out_d.out_valid = 1'b1;
          out_d.out_idx   = o_d;
        end
      end
      DONE: out_d.done = 1'b1;
      default: ;
    endcase
    // The IFIFO is never used and xmem is only ever read.
    out_d.inst[IFWR_B] = 1'b0;
    out_d.inst[IFRD_B] = 1'b0;
    out_d.inst[WENX_B] = 1'b1;
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      kij_q   <= '0;
      o_q     <= '0;
      c_q     <= '0;
      out_q   <= OUT_IDLE;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values regardless of statement order.
      state_q <= state_d;
      t_q     <= t_d;
      kij_q   <= kij_d;
      o_q     <= o_d;
      c_q     <= c_d;
      out_q   <= out_d;
    end
  end

  assign inst      = out_q.inst;
  assign core_rst  = out_q.core_rst;
  assign busy      = out_q.busy;
  assign done      = out_q.done;
  assign out_valid = out_q.out_valid;
  assign out_idx   = out_q.out_idx;
  assign kij_idx   = kij_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: builds the expected per-cycle output trace of a
// whole tile from the phase rules, replays it against the DUT, and adds
// hand-written abort / reset / start-while-busy sequences.
module tb_conv_seq_ctrl;

  localparam int TAPS   = 9;
  localparam int STRIDE = 37;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic [3:0]  kij_idx;

  conv_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .core_rst    (core_rst),
    .busy        (busy),
    .done        (done),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .kij_idx     (kij_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected cycle: inst fields, side outputs, and the ofifo_valid to drive.
  typedef struct {
    bit acc; bit cen_p; bit wen_p; int a_p; bit cen_x; int a_x;
    bit ofrd; bit l0rd; bit l0wr; bit exec; bit load;
    bit core_rst; bit busy; bit done; bit out_valid; int out_idx; int kij_idx;
    bit ofv_care; bit ofv;
  } vec_t;

  vec_t exp_q[$];
  int   owait_w[TAPS];
  int   idx_exec10, idx_ofifo5, idx_kij3, idx_o5j4, idx_o0j0;
  int   n_pass  = 0;
  int   n_total = 0;

  // Statistics gathered from the DUT during the directed full run.
  int wl0_cnt, load_cnt, exec_cnt, ofrd_cnt, ov_cnt, done_cnt, last_ov;
  int ax_min[2], ax_max[2], ap_min[2], ap_max[2];
  int ap_o5j4, ap_o0j0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic vec_t base(input int kij, input bit busy_v);
    vec_t v;
    v = '{default: 0};
    v.cen_p = 1; v.wen_p = 1; v.cen_x = 1;
    v.busy = busy_v; v.kij_idx = kij;
    return v;
  endfunction

  function automatic logic [45:0] pack_exp(input vec_t v);
    return {v.acc, v.cen_p, v.wen_p, 11'(v.a_p), v.cen_x, 1'b1, 11'(v.a_x),
            v.ofrd, 2'b00, v.l0rd, v.l0wr, v.exec, v.load,
            v.core_rst, v.busy, v.done, v.out_valid, 4'(v.out_idx), 4'(v.kij_idx)};
  endfunction

  function automatic logic [45:0] got_vec();
    return {inst, core_rst, busy, done, out_valid, out_idx, kij_idx};
  endfunction

  function automatic int psum_addr(input int o, input int j);
    return j * STRIDE + (o / 4 + j / 3) * 6 + (o % 4 + j % 3);
  endfunction

  // Expected trace of a full tile, given the OWAIT hold per kij.
  task automatic build_trace();
    vec_t v;
    exp_q.delete();
    for (int kij = 0; kij < TAPS; kij++) begin
      for (int t = 0; t < 11; t++) begin
        if (kij == 3 && t == 3) idx_kij3 = exp_q.size();
        v = base(kij, 1); v.core_rst = 1; exp_q.push_back(v);
      end
      for (int t = 0; t <= 8; t++) begin
        v = base(kij, 1); v.cen_x = 0; v.a_x = 1024 + kij * 8 + t; v.l0wr = (t > 0);
        exp_q.push_back(v);
      end
      for (int t = 0; t < 8; t++) begin
        v = base(kij, 1); v.l0rd = 1; v.load = 1; exp_q.push_back(v);
      end
      for (int t = 0; t < 11; t++) exp_q.push_back(base(kij, 1));
      for (int t = 0; t <= 36; t++) begin
        v = base(kij, 1); v.cen_x = 0; v.a_x = t; v.l0wr = (t > 0); exp_q.push_back(v);
      end
      for (int t = 0; t < 36; t++) begin
        if (kij == 0 && t == 10) idx_exec10 = exp_q.size();
        v = base(kij, 1); v.exec = 1; v.l0rd = 1; exp_q.push_back(v);
      end
      for (int t = 0; t < 16; t++) exp_q.push_back(base(kij, 1));
      for (int i = 0; i <= owait_w[kij]; i++) begin
        v = base(kij, 1); v.ofv_care = 1; v.ofv = (i == owait_w[kij]); exp_q.push_back(v);
      end
      for (int t = 0; t < STRIDE; t++) begin
        if (kij == 1 && t == 5) idx_ofifo5 = exp_q.size();
        v = base(kij, 1); v.ofrd = 1; v.cen_p = 0; v.wen_p = 0; v.a_p = kij * STRIDE + t;
        exp_q.push_back(v);
      end
    end
    for (int o = 0; o < 16; o++) begin
      for (int c = 0; c < 12; c++) begin
        v = base(TAPS - 1, 1);
        if (c == 0) v.core_rst = 1;
        if (c >= 1 && c <= 9) begin
          if (o == 5 && c == 5) idx_o5j4 = exp_q.size();
          if (o == 0 && c == 1) idx_o0j0 = exp_q.size();
          v.cen_p = 0; v.a_p = psum_addr(o, c - 1);
        end
        v.acc = (c >= 2 && c <= 10);
        if (c == 11) begin v.out_valid = 1; v.out_idx = o; end
        exp_q.push_back(v);
      end
    end
    v = base(TAPS - 1, 1); v.done = 1; exp_q.push_back(v);
  endtask

  task automatic collect_stats(input int k);
    int kj;
    kj = int'(kij_idx);
    if (kj < 2 && busy) begin
      if (!inst[19] && int'(inst[17:7]) >= 1024) begin
        if (int'(inst[17:7]) < ax_min[kj]) ax_min[kj] = int'(inst[17:7]);
        if (int'(inst[17:7]) > ax_max[kj]) ax_max[kj] = int'(inst[17:7]);
        if (kj == 0 && inst[2]) wl0_cnt++;
      end
      if (inst[6]) begin
        if (int'(inst[30:20]) < ap_min[kj]) ap_min[kj] = int'(inst[30:20]);
        if (int'(inst[30:20]) > ap_max[kj]) ap_max[kj] = int'(inst[30:20]);
        if (kj == 0) ofrd_cnt++;
      end
      if (kj == 0 && inst[0]) load_cnt++;
      if (kj == 0 && inst[1]) exec_cnt++;
    end
    if (k == idx_o5j4) ap_o5j4 = int'(inst[30:20]);
    if (k == idx_o0j0) ap_o0j0 = int'(inst[30:20]);
    if (done) done_cnt++;
    if (out_valid) begin
      check("out_idx order", 64'(out_idx), 64'(ov_cnt));
      if (ov_cnt > 0) check("out_valid spacing", 64'(k - last_ov), 64'd12);
      last_ov = k;
      ov_cnt++;
    end
  endtask

  task automatic check_idle(input string name);
    check(name, 64'(got_vec()), 64'(pack_exp(base(0, 0))));
  endtask

  // Replays exp_q. abort_k / reset_k cut the run short; start_k pulses start while busy.
  task automatic run_trace(input int abort_k, input int reset_k, input int start_k,
                           input bit rand_in, input bit do_stats);
    @(negedge clk);
    start = 1'b1; abort = 1'b0; ofifo_valid = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      check($sformatf("cycle %0d", k), 64'(got_vec()), 64'(pack_exp(exp_q[k])));
      if (do_stats) collect_stats(k);
      start = 1'b0;
      abort = 1'b0;
      if (exp_q[k].ofv_care) ofifo_valid = exp_q[k].ofv;
      else                   ofifo_valid = rand_in ? 1'($urandom) : 1'b1;
      if (rand_in && $urandom_range(7) == 0) start = 1'b1;
      if (k == start_k) start = 1'b1;
      if (k == abort_k) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("idle after abort");
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_idle("no done after abort");
        end
        return;
      end
      if (k == reset_k) begin
        #2 reset = 1'b0;
        #1 check_idle("async reset mid-OFIFO");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("idle after reset release");
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check_idle("idle after done");
    @(negedge clk);
    check_idle("stays idle");
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; ofifo_valid = 1'b0;
    // Reset and idle behaviour.
    repeat (5) @(negedge clk);
    check("reset inst", 64'(inst), 64'h1_800C_0000);
    check_idle("reset outputs");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("idle with start low");
    end

    // start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_idle("start+abort stays idle");
    @(negedge clk);
    check_idle("start+abort still idle");

    // Directed full tile: ofifo_valid held off 20 cycles at kij2, start pulsed in kij3.
    foreach (owait_w[i]) owait_w[i] = 0;
    owait_w[2] = 20;
    build_trace();
    wl0_cnt = 0; load_cnt = 0; exec_cnt = 0; ofrd_cnt = 0;
    ov_cnt = 0; done_cnt = 0; last_ov = 0; ap_o5j4 = -1; ap_o0j0 = -1;
    for (int i = 0; i < 2; i++) begin
      ax_min[i] = 4096; ax_max[i] = -1; ap_min[i] = 4096; ap_max[i] = -1;
    end
    run_trace(-1, -1, idx_kij3, 1'b0, 1'b1);
    check("kij0 weight l0_wr count", 64'(wl0_cnt), 64'd8);
    check("kij0 load count", 64'(load_cnt), 64'd8);
    check("kij0 execute count", 64'(exec_cnt), 64'd36);
    check("kij0 ofifo_rd count", 64'(ofrd_cnt), 64'd37);
    check("kij0 A_x min", 64'(ax_min[0]), 64'd1024);
    check("kij0 A_x max", 64'(ax_max[0]), 64'd1032);
    check("kij1 A_x min", 64'(ax_min[1]), 64'd1032);
    check("kij1 A_x max", 64'(ax_max[1]), 64'd1040);
    check("kij0 A_p min", 64'(ap_min[0]), 64'd0);
    check("kij0 A_p max", 64'(ap_max[0]), 64'd36);
    check("kij1 A_p min", 64'(ap_min[1]), 64'd37);
    check("kij1 A_p max", 64'(ap_max[1]), 64'd73);
    check("ACC o5 j4 A_p", 64'(ap_o5j4), 64'd162);
    check("ACC o0 j0 A_p", 64'(ap_o0j0), 64'd0);
    check("out_valid pulses", 64'(ov_cnt), 64'd16);
    check("done pulses", 64'(done_cnt), 64'd1);

    // Randomized OWAIT holds, random ofifo_valid elsewhere, random start while busy.
    foreach (owait_w[i]) owait_w[i] = int'($urandom_range(6));
    build_trace();
    run_trace(-1, -1, -1, 1'b1, 1'b0);

    // Abort in EXEC at t=10 of kij0, then a fresh randomized tile.
    foreach (owait_w[i]) owait_w[i] = 0;
    build_trace();
    run_trace(idx_exec10, -1, -1, 1'b0, 1'b0);
    foreach (owait_w[i]) owait_w[i] = int'($urandom_range(4));
    build_trace();
    run_trace(-1, -1, -1, 1'b1, 1'b0);

    // Reset in the middle of kij1 OFIFO, then a fresh tile from cleared counters.
    foreach (owait_w[i]) owait_w[i] = 0;
    build_trace();
    run_trace(-1, idx_ofifo5, -1, 1'b0, 1'b0);
    foreach (owait_w[i]) owait_w[i] = int'($urandom_range(3));
    build_trace();
    run_trace(-1, -1, -1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
